// File: rtl/stream_fetch_engine_if.sv
// Command, memory-read and output-stream signals of the fetch engine.
// The master modport is the engine side and the slave modport is the environment side.
interface stream_fetch_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
);
    logic                  cmd_vld;
    logic                  cmd_rdy;
    logic [ADDR_WIDTH-1:0] cmd_base;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic [ADDR_WIDTH-1:0] cmd_stride;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  out_vld;
    logic                  out_rdy;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        input  cmd_vld, cmd_base, cmd_len, cmd_stride, mem_rvalid, mem_rdata, out_rdy,
        output cmd_rdy, mem_req, mem_addr, out_vld, out_data, out_last
    );

    modport slave (
        output cmd_vld, cmd_base, cmd_len, cmd_stride, mem_rvalid, mem_rdata, out_rdy,
        input  cmd_rdy, mem_req, mem_addr, out_vld, out_data, out_last
    );
endinterface

// File: rtl/stream_fetch_engine.sv
// Strided word fetcher: the first mem_req appears 1 cycle after command accept, and returns are queued in a FIFO and streamed out.
// Credit issue keeps (in flight + queued) <= FIFO_DEPTH, so out_rdy backpressure only stalls requests and never drops data.
// Notes: returns are ignored outside FETCH. After a reset, memory must be quiesced by the integrator before the next command.
module stream_fetch_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stream_fetch_engine_if.master bus,
    output logic                  busy,
    output logic                  done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] stride_q, addr_q;
    logic [LEN_WIDTH-1:0]  issue_cnt, deliver_cnt, ret_left;
    logic [CW-1:0]         outstanding, fifo_count;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [DATA_WIDTH:0]   fifo_mem [FIFO_DEPTH];
    logic                  mem_req_q, cmd_rdy_c;
    logic                  accept, first_issue, issue, any_issue, push, pop, fifo_nempty;
    logic [CW:0]           credit_sum;

    assign accept      = (state == IDLE) && bus.cmd_vld;
    assign first_issue = accept && (bus.cmd_len != '0);
    assign credit_sum  = {1'b0, outstanding} + {1'b0, fifo_count};
    assign issue       = (state == FETCH) && (issue_cnt != '0) && (credit_sum < (CW+1)'(FIFO_DEPTH));
    assign any_issue   = first_issue || issue;
    assign push        = bus.mem_rvalid && (state == FETCH);
    assign fifo_nempty = (fifo_count != '0);
    assign pop         = fifo_nempty && bus.out_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_rdy_c = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy      = 1'b0;
                cmd_rdy_c = 1'b1;
                if (bus.cmd_vld) state_nxt = (bus.cmd_len == '0) ? DONE : FETCH;
            end
            FETCH: if (pop && (deliver_cnt == LEN_WIDTH'(1))) state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The first request is issued straight from the command so that it appears one cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req_q   <= 1'b0;
            addr_q      <= '0;
            stride_q    <= '0;
            issue_cnt   <= '0;
            deliver_cnt <= '0;
            ret_left    <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            mem_req_q <= any_issue;
            if (accept) begin
                stride_q    <= bus.cmd_stride;
                addr_q      <= bus.cmd_base;
                issue_cnt   <= (bus.cmd_len == '0) ? '0 : bus.cmd_len - LEN_WIDTH'(1);
                deliver_cnt <= bus.cmd_len;
                ret_left    <= bus.cmd_len;
            end else if (issue) begin
                addr_q    <= addr_q + stride_q;
                issue_cnt <= issue_cnt - LEN_WIDTH'(1);
            end
            if (pop)  deliver_cnt <= deliver_cnt - LEN_WIDTH'(1);
            if (push) ret_left    <= ret_left - LEN_WIDTH'(1);
            case ({any_issue, push})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {(ret_left == LEN_WIDTH'(1)), bus.mem_rdata};
    end

    assign bus.cmd_rdy  = cmd_rdy_c;
    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = addr_q;
    assign bus.out_vld  = fifo_nempty;
    assign {bus.out_last, bus.out_data} = fifo_nempty ? fifo_mem[rd_ptr] : '0;

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (fifo_count == CW'(FIFO_DEPTH))));
endmodule

// File: tb/tb_stream_fetch_engine.sv
// Randomised bench for stream_fetch_engine: an in-order memory with variable latency, a random out_rdy,
// and expected addresses and beats derived from base + i*stride.
module tb_stream_fetch_engine;
    localparam int DW = 32, AW = 16, LW = 8, DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, done;
    always #5 clk = ~clk;

    stream_fetch_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();
    stream_fetch_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .done(done));

    int chk_cnt = 0, pass_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return 32'hC0DE_0000 ^ ({16'h0, a} * 32'h0001_9E37);
    endfunction

    // Environment and model state.
    int cyc = 0, rdy_mode = 0, lat_min = 2, lat_max = 2, last_due = 0;
    int due_q[$];
    logic [31:0] rdat_q[$];
    logic [15:0] exp_addr_q[$];
    logic [32:0] exp_beat_q[$];
    int done_due = -10, open_cmds = 0, issued = 0, delivered = 0;
    bit exp_busy = 1'b0, prev_hold = 1'b0;
    logic [32:0] prev_beat = '0;
    logic [15:0] req_addr_log[$];
    int req_cyc_log[$];
    int beats = 0, lasts = 0, vld_cycles = 0;
    int acc_cyc = 0, last_hs_cyc = 0, done_cyc = 0, rdy_back_cyc = 0;

    initial begin
        int d;
        logic [31:0] tmp;
        logic [15:0] a;
        logic [32:0] e;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.out_rdy    = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                due_q.delete(); rdat_q.delete(); exp_addr_q.delete(); exp_beat_q.delete();
                last_due = 0; done_due = -10; open_cmds = 0; issued = 0; delivered = 0;
                exp_busy = 1'b0; prev_hold = 1'b0; bus.mem_rvalid = 1'b0;
                continue;
            end
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rdat_q.pop_front();
                void'(due_q.pop_front());
            end else begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = $urandom;
            end
            if (bus.mem_req) begin
                d = cyc + $urandom_range(lat_max, lat_min);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                due_q.push_back(d);
                rdat_q.push_back(mem_word(bus.mem_addr));
                req_addr_log.push_back(bus.mem_addr);
                req_cyc_log.push_back(cyc);
                issued++;
                if (exp_addr_q.size() == 0) check("spurious_req", 1, 0);
                else check("mem_addr", bus.mem_addr, exp_addr_q.pop_front());
            end
            check("credit", 64'((issued - delivered) <= DEPTH), 1);
            case (rdy_mode)
                0:       bus.out_rdy = 1'b1;
                1:       bus.out_rdy = 1'b0;
                default: bus.out_rdy = 1'($urandom_range(1, 0));
            endcase
            if (prev_hold) begin
                check("hold_vld", bus.out_vld, 1);
                check("hold_dat", {bus.out_last, bus.out_data}, prev_beat);
            end
            if (bus.out_vld) vld_cycles++;
            if (bus.out_vld && bus.out_rdy) begin
                if (exp_beat_q.size() == 0) check("spurious_beat", 1, 0);
                else begin
                    e = exp_beat_q.pop_front();
                    check("beat", {bus.out_last, bus.out_data}, e);
                    beats++;
                    delivered++;
                    if (bus.out_last) lasts++;
                    if (e[32]) begin
                        done_due    = cyc + 1;
                        last_hs_cyc = cyc;
                    end
                end
            end
            prev_hold = bus.out_vld && !bus.out_rdy;
            prev_beat = {bus.out_last, bus.out_data};
            check("done", done, 64'(cyc == done_due));
            check("busy", busy, exp_busy);
            check("cmd_rdy", bus.cmd_rdy, !exp_busy);
            if (done) done_cyc = cyc;
            if (bus.cmd_rdy && rdy_back_cyc < 0) rdy_back_cyc = cyc;
            if (cyc == done_due) begin
                exp_busy = 1'b0;
                open_cmds--;
            end
            if (bus.cmd_vld && bus.cmd_rdy) begin
                acc_cyc = cyc;
                rdy_back_cyc = -1;
                for (int i = 0; i < int'(bus.cmd_len); i++) begin
                    tmp = {16'h0, bus.cmd_base} + 32'(i) * {16'h0, bus.cmd_stride};
                    a = tmp[15:0];
                    exp_addr_q.push_back(a);
                    exp_beat_q.push_back({(i == int'(bus.cmd_len) - 1), mem_word(a)});
                end
                if (bus.cmd_len == '0) done_due = cyc + 1;
                exp_busy = 1'b1;
                open_cmds++;
            end
        end
    end

    task automatic clear_logs();
        req_addr_log.delete();
        req_cyc_log.delete();
        beats = 0; lasts = 0; vld_cycles = 0;
    endtask

    task automatic send_cmd(input logic [15:0] b, input logic [7:0] l, input logic [15:0] s);
        int n = 0;
        @(posedge clk); #1;
        bus.cmd_vld = 1'b1; bus.cmd_base = b; bus.cmd_len = l; bus.cmd_stride = s;
        while (1) begin
            @(negedge clk);
            if (bus.cmd_rdy) break;
            n++;
            if (n > 200) begin
                check("cmd_accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        bus.cmd_vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (open_cmds != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("idle_timeout", 64'(open_cmds == 0), 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_reset(input string p);
        check({p, "_cmd_rdy"}, bus.cmd_rdy, 1);
        check({p, "_mem_req"}, bus.mem_req, 0);
        check({p, "_mem_addr"}, bus.mem_addr, 0);
        check({p, "_out_vld"}, bus.out_vld, 0);
        check({p, "_out_data"}, bus.out_data, 0);
        check({p, "_out_last"}, bus.out_last, 0);
        check({p, "_busy"}, busy, 0);
        check({p, "_done"}, done, 0);
    endtask

    initial begin
        logic [15:0] wrap_exp [3];
        int lsum, n;
        logic [7:0] l;
        wrap_exp = '{16'hFFFE, 16'h0001, 16'h0004};
        bus.cmd_vld = 1'b0; bus.cmd_base = '0; bus.cmd_len = '0; bus.cmd_stride = '0;
        repeat (3) @(posedge clk); #1;
        check_reset("init");
        rst_n = 1'b1;

        // Basic stream.
        clear_logs();
        send_cmd(16'h0010, 8'd4, 16'd1);
        wait_idle();
        check("basic_nreq", req_addr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < req_addr_log.size()) begin
                check("basic_addr", req_addr_log[i], 64'(16'h0010 + i));
                check("basic_req_cyc", req_cyc_log[i], 64'(acc_cyc + 1 + i));
            end
        end
        check("basic_beats", beats, 4);
        check("basic_lasts", lasts, 1);
        check("basic_done_gap", 64'(done_cyc - last_hs_cyc), 1);

        // Backpressure.
        clear_logs();
        rdy_mode = 1;
        send_cmd(16'h0200, 8'd8, 16'd1);
        repeat (20) @(posedge clk);
        #1;
        check("bp_stall_nreq", req_addr_log.size(), DEPTH);
        check("bp_stall_vld", bus.out_vld, 1);
        rdy_mode = 0;
        wait_idle();
        check("bp_nreq", req_addr_log.size(), 8);
        check("bp_beats", beats, 8);
        check("bp_lasts", lasts, 1);

        // Stride and wrap.
        clear_logs();
        send_cmd(16'hFFFE, 8'd3, 16'd3);
        wait_idle();
        check("wrap_nreq", req_addr_log.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < req_addr_log.size()) check("wrap_addr", req_addr_log[i], wrap_exp[i]);

        // Zero length.
        clear_logs();
        send_cmd(16'h0055, 8'd0, 16'd7);
        wait_idle();
        check("zero_nreq", req_addr_log.size(), 0);
        check("zero_vld", vld_cycles, 0);
        check("zero_done_gap", 64'(done_cyc - acc_cyc), 1);
        check("zero_rdy_gap", 64'(rdy_back_cyc - acc_cyc), 2);

        // Random ready and latency.
        clear_logs();
        rdy_mode = 2; lat_min = 1; lat_max = 5;
        send_cmd(16'($urandom), 8'd32, 16'($urandom));
        wait_idle();
        lsum = 32;
        for (int k = 0; k < 4; k++) begin
            l = 8'($urandom_range(20, 1));
            lsum += int'(l);
            send_cmd(16'($urandom), l, 16'($urandom));
            wait_idle();
        end
        check("rand_beats", beats, lsum);
        check("rand_lasts", lasts, 5);

        // Reset mid-run.
        clear_logs();
        rdy_mode = 0; lat_min = 2; lat_max = 2;
        send_cmd(16'h0300, 8'd8, 16'd2);
        n = 0;
        while (beats < 3 && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("rst_progress", beats, 3);
        #2 rst_n = 1'b0;
        #1 check_reset("midrst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_logs();
        send_cmd(16'h0400, 8'd2, 16'd1);
        wait_idle();
        check("post_beats", beats, 2);
        check("post_lasts", lasts, 1);
        check("post_nreq", req_addr_log.size(), 2);
        if (req_addr_log.size() == 2) begin
            check("post_addr0", req_addr_log[0], 16'h0400);
            check("post_addr1", req_addr_log[1], 16'h0401);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/stream_fetch_engine.md
Name: stream_fetch_engine

Overview:
- Producer end of the valid/ready tile stream. Sits upstream of the skid buffer feeding the matrix core.
- Accepts a fetch command (base, length, stride) and issues word reads to local memory.
- Queues in-order read returns in an internal FIFO and emits them as an out_vld/out_rdy stream, with out_last on the final beat.
- Credit-based request issue: no read return is ever dropped, whatever out_rdy does.

Parameters:
- DATA_WIDTH, 32, width of a memory word and stream beat
- ADDR_WIDTH, 16, memory word-address width
- LEN_WIDTH, 8, width of the command beat count
- FIFO_DEPTH, 4, return FIFO entries; power of two, >= 2

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  command ready; high only in IDLE
- cmd_base  in  ADDR_WIDTH  first word address
- cmd_len  in  LEN_WIDTH  number of beats; 0 is legal
- cmd_stride  in  ADDR_WIDTH  address increment per beat
- mem_req  out  1  read request strobe; memory always accepts
- mem_addr  out  ADDR_WIDTH  read address, valid with mem_req
- mem_rvalid  in  1  read return strobe; in order, latency >= 1, arbitrary
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_rvalid
- out_vld  out  1  stream valid
- out_rdy  in  1  stream ready
- out_data  out  DATA_WIDTH  stream beat
- out_last  out  1  marks the final beat of a command
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset values (rst_n asynchronous, active-low, clock clk): state IDLE, FIFO empty, counters 0. Outputs: cmd_rdy=1, mem_req=0, mem_addr=0, out_vld=0, out_data=0, out_last=0, busy=0, done=0.
- Stream contract:
  - A transfer happens only on out_vld && out_rdy at a rising edge.
  - out_vld = FIFO non-empty. It has no combinational path from out_rdy.
  - out_data and out_last come from the FIFO head and hold stable until the handshake.
- State IDLE:
  - cmd_rdy=1.
  - On cmd_vld, latch base, stride and len; set issue_cnt=len, deliver_cnt=len; go to FETCH.
  - If len=0, go to DONE instead.
- State FETCH:
  - Issue condition: issue_cnt>0 and (outstanding + fifo_count) < FIFO_DEPTH.
  - When it holds, mem_req=1 (registered) with mem_addr = current address.
  - Address advances by stride, mod 2^ADDR_WIDTH; wrap-around is silent.
  - Each issue decrements issue_cnt.
  - First mem_req occurs in the cycle after command acceptance.
  - Max one request per cycle; back-to-back issue is allowed.
  - After the last issue, the block stays in FETCH until deliver_cnt reaches 0.
- outstanding counter:
  - +1 on issue, -1 on mem_rvalid. Both in the same cycle leaves it unchanged.
  - Each mem_rvalid pushes mem_rdata into the FIFO.
  - The credit rule guarantees the push never finds the FIFO full. A push while full is a bug; flag it with an assertion.
- FIFO:
  - Push and pop in the same cycle are both legal, including when empty-with-push (pop is impossible then, since out_vld=0).
  - An entry is marked last when it is the final beat, i.e. return count equals len.
- Delivery: each out handshake decrements deliver_cnt. The handshake that drives deliver_cnt to 0 must be the one carrying out_last=1.
- State DONE:
  - Entered the cycle after the final handshake, or directly from IDLE when len=0.
  - done=1 for exactly one cycle, then IDLE.
  - cmd_rdy is not asserted until IDLE, so command-to-command gap >= 2 cycles.
- busy=1 in FETCH and DONE.
- Width rules:
  - Counters are LEN_WIDTH bits.
  - outstanding and fifo_count are clog2(FIFO_DEPTH)+1 bits.
  - A sum >= FIFO_DEPTH blocks issue.
- Reset mid-operation:
  - Everything returns to reset values immediately.
  - Memory returns for requests issued before reset are ignored until the first post-reset command. Memory must be quiesced by the integrator; document this in the top-level notes.
- out_rdy held low indefinitely: at most FIFO_DEPTH reads are in flight or queued, then mem_req stays 0 and nothing is lost.

Test Plan:
- Basic stream: cmd base=0x0010, len=4, stride=1, memory latency 2, out_rdy=1.
  - mem_addr sequence is 0x10, 0x11, 0x12, 0x13 on consecutive cycles.
  - Four beats emerge in order with out_last only on the 4th.
  - done pulses one cycle after the 4th handshake.
- Backpressure: len=8, FIFO_DEPTH=4, out_rdy=0 for 20 cycles, then 1.
  - Exactly 4 mem_req pulses while stalled.
  - out_vld stays high with out_data stable.
  - All 8 beats then arrive in order; no overflow assertion fires.
- Stride and wrap: base=0xFFFE, stride=3, len=3.
  - mem_addr sequence is 0xFFFE, 0x0001, 0x0004.
- Zero length: cmd len=0.
  - No mem_req, no out_vld.
  - done pulses in the cycle after acceptance; cmd_rdy returns the next cycle.
- Random ready and latency: out_rdy toggled randomly at 50%, mem latency random in 1..5, len=32.
  - Output matches the scoreboard, out_last appears exactly once, and valid never drops without a handshake.
- Reset mid-run: assert rst_n=0 after 3 of 8 beats are delivered.
  - All outputs at reset values within the reset cycle.
  - A fresh len=2 command afterwards completes normally.
